// File: rtl/usb_bridge_pkg.sv
// Shared types for the USB FIFO bridge: FSM state encoding, mode bits and
// the bus-width legality helper.
package usb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_TURN = 3'd1,
        RX_DATA = 3'd2,
        TX_DATA = 3'd3,
        GAP     = 3'd4
    } bridge_state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_TX   = 2'b01;
    localparam logic [1:0] MODE_RX   = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam int MODE_TX_BIT = 0;
    localparam int MODE_RX_BIT = 1;

    function automatic bit data_w_legal(input int width);
        return (width == 16) || (width == 32);
    endfunction

endpackage

// File: rtl/usb_fifo_bridge_sync_fifo.sv
// First-word-fall-through single-clock FIFO with occupancy output; used for
// both directions of the USB bridge.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only taken when the head leaves on the
    // same edge, so the level holds at DEPTH instead of overflowing.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/usb_fifo_bridge.sv
// Bridges a half-duplex FT-style USB FIFO bus to two fabric streams, with a
// buffer per direction and round-robin bus arbitration in bounded bursts.
module usb_fifo_bridge
    import usb_bridge_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int DEPTH     = 16,
    parameter int BURST_MAX = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [1:0]             mode_in,
    input  logic                   usb_txe_n_in,
    input  logic                   usb_rxf_n_in,
    output logic                   usb_wr_n_out,
    output logic                   usb_rd_n_out,
    output logic                   usb_oe_n_out,
    inout  wire  [DATA_W-1:0]      usb_data_io,
    inout  wire  [BE_W-1:0]        usb_be_io,
    input  logic [DATA_W-1:0]      tx_data_in,
    input  logic [BE_W-1:0]        tx_be_in,
    input  logic                   tx_valid_in,
    output logic                   tx_ready_out,
    output logic [DATA_W-1:0]      rx_data_out,
    output logic [BE_W-1:0]        rx_be_out,
    output logic                   rx_valid_out,
    input  logic                   rx_ready_in,
    output logic [$clog2(DEPTH):0] tx_level_out,
    output logic [$clog2(DEPTH):0] rx_level_out
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(BURST_MAX) + 1;
    localparam int FW = DATA_W + BE_W;

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("usb_fifo_bridge: DATA_W must be 16 or 32");
    end

    bridge_state_t state;
    logic [1:0]    rst_sync;
    logic          run;
    logic [BW-1:0] burst_cnt;
    logic          burst_last;
    logic          prefer_rx;
    logic          bus_drive;

    logic [FW-1:0] tx_head;
    logic          tx_full;
    logic          tx_empty;
    logic [LW-1:0] tx_level;
    logic          tx_push;
    logic          tx_pop;
    logic [LW-1:0] tx_level_next;

    logic [FW-1:0] rx_head;
    logic          rx_full;
    logic          rx_empty;
    logic [LW-1:0] rx_level;
    logic          rx_push;
    logic          rx_pop;
    logic [LW-1:0] rx_level_next;

    logic          rx_req;
    logic          tx_req;

    // The FSM is held still until two clocks after reset release, so a
    // reset deasserting near an edge cannot start a half-formed bus cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    assign tx_push      = tx_valid_in & tx_ready_out;
    assign tx_ready_out = ~tx_full;
    assign tx_pop       = (state == TX_DATA) & ~usb_wr_n_out & ~usb_txe_n_in & ~tx_empty;

    sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (tx_push),
        .push_data ({tx_data_in, tx_be_in}),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    assign rx_push      = (state == RX_DATA) & ~usb_rd_n_out & ~usb_rxf_n_in & ~rx_full;
    assign rx_valid_out = ~rx_empty;
    assign rx_pop       = rx_valid_out & rx_ready_in;

    sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (rx_push),
        .push_data ({usb_data_io, usb_be_io}),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign rx_data_out  = rx_head[FW-1:BE_W];
    assign rx_be_out    = rx_head[BE_W-1:0];
    assign tx_level_out = tx_level;
    assign rx_level_out = rx_level;

    assign tx_level_next = tx_level - LW'(tx_pop) + LW'(tx_push);
    assign rx_level_next = rx_level + LW'(rx_push) - LW'(rx_pop);
    assign burst_last    = (burst_cnt + BW'(1)) == BW'(BURST_MAX);

    // RX is only requested with two free slots: the read strobe is
    // registered, so one more word can land before the exit takes effect.
    assign rx_req = mode_in[MODE_RX_BIT] & ~usb_rxf_n_in & (rx_level <= LW'(DEPTH - 2));
    assign tx_req = mode_in[MODE_TX_BIT] & ~usb_txe_n_in & (tx_level != '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            usb_wr_n_out <= 1'b1;
            usb_rd_n_out <= 1'b1;
            usb_oe_n_out <= 1'b1;
            bus_drive    <= 1'b0;
            burst_cnt    <= '0;
            prefer_rx    <= 1'b1;
        end else if (run) begin
            case (state)
                IDLE: begin
                    if (rx_req && (!tx_req || prefer_rx)) begin
                        state        <= RX_TURN;
                        usb_oe_n_out <= 1'b0;
                        prefer_rx    <= 1'b0;
                    end else if (tx_req) begin
                        state        <= TX_DATA;
                        usb_wr_n_out <= 1'b0;
                        bus_drive    <= 1'b1;
                        burst_cnt    <= '0;
                        prefer_rx    <= 1'b1;
                    end
                end
                RX_TURN: begin
                    state        <= RX_DATA;
                    usb_rd_n_out <= 1'b0;
                    burst_cnt    <= '0;
                end
                RX_DATA: begin
                    if (rx_push) burst_cnt <= burst_cnt + BW'(1);
                    if (usb_rxf_n_in || rx_full ||
                        (rx_push && (burst_last || rx_level_next > LW'(DEPTH - 2)))) begin
                        state        <= GAP;
                        usb_rd_n_out <= 1'b1;
                        usb_oe_n_out <= 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_pop) burst_cnt <= burst_cnt + BW'(1);
                    if (usb_txe_n_in || tx_empty ||
                        (tx_pop && (burst_last || tx_level_next == '0))) begin
                        state        <= GAP;
                        usb_wr_n_out <= 1'b1;
                        bus_drive    <= 1'b0;
                    end
                end
                GAP: begin
                    state        <= IDLE;
                    usb_wr_n_out <= 1'b1;
                    usb_rd_n_out <= 1'b1;
                    usb_oe_n_out <= 1'b1;
                    bus_drive    <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    usb_wr_n_out <= 1'b1;
                    usb_rd_n_out <= 1'b1;
                    usb_oe_n_out <= 1'b1;
                    bus_drive    <= 1'b0;
                end
            endcase
        end
    end

    assign usb_data_io = bus_drive ? tx_head[FW-1:BE_W] : {DATA_W{1'bz}};
    assign usb_be_io   = bus_drive ? tx_head[BE_W-1:0]  : {BE_W{1'bz}};

endmodule

// File: tb/tb_usb_fifo_bridge.sv
// Directed bench for usb_fifo_bridge: a behavioural USB device on the bus
// side, fabric streams driven from the stimulus process.
module tb_usb_fifo_bridge;

    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam int DEPTH     = 16;
    localparam int BURST_MAX = 8;
    localparam int LW        = 5;
    localparam byte G_R      = 8'h52;
    localparam byte G_T      = 8'h54;

    logic              clk_in       = 1'b0;
    logic              rst_n_in     = 1'b0;
    logic [1:0]        mode_in      = 2'b00;
    logic              usb_txe_n_in = 1'b1;
    logic              usb_rxf_n_in = 1'b1;
    logic              usb_wr_n_out;
    logic              usb_rd_n_out;
    logic              usb_oe_n_out;
    wire  [DATA_W-1:0] usb_data_io;
    wire  [BE_W-1:0]   usb_be_io;
    logic [DATA_W-1:0] tx_data_in   = '0;
    logic [BE_W-1:0]   tx_be_in     = '0;
    logic              tx_valid_in  = 1'b0;
    logic              tx_ready_out;
    logic [DATA_W-1:0] rx_data_out;
    logic [BE_W-1:0]   rx_be_out;
    logic              rx_valid_out;
    logic              rx_ready_in  = 1'b0;
    logic [LW-1:0]     tx_level_out;
    logic [LW-1:0]     rx_level_out;

    int check_count = 0;
    int error_count = 0;

    // Device-model state, owned by the negedge process below.
    int          dev_count = 0;
    int          dev_idx   = 0;
    bit          dev_take  = 1'b0;
    logic [31:0] dev_data  = '0;
    logic [3:0]  dev_be    = '0;
    int          tx_limit  = 1000;
    int          tx_acc    = 0;
    logic [31:0] tx_words[$];
    logic [3:0]  tx_bes[$];
    logic [31:0] rx_words[$];
    logic [3:0]  rx_bes[$];
    byte         grants[$];
    int          burst_log[$];
    int          burst_takes   = 0;
    int          wr_low_cycles = 0;
    int          oe_low_cycles = 0;
    int          turn_cycles   = 0;
    logic [31:0] held_word     = '0;
    logic        prev_oe = 1'b1;
    logic        prev_wr = 1'b1;
    logic        prev_rd = 1'b1;
    bit          found;

    usb_fifo_bridge #(
        .DATA_W(DATA_W), .BE_W(BE_W), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .mode_in      (mode_in),
        .usb_txe_n_in (usb_txe_n_in),
        .usb_rxf_n_in (usb_rxf_n_in),
        .usb_wr_n_out (usb_wr_n_out),
        .usb_rd_n_out (usb_rd_n_out),
        .usb_oe_n_out (usb_oe_n_out),
        .usb_data_io  (usb_data_io),
        .usb_be_io    (usb_be_io),
        .tx_data_in   (tx_data_in),
        .tx_be_in     (tx_be_in),
        .tx_valid_in  (tx_valid_in),
        .tx_ready_out (tx_ready_out),
        .rx_data_out  (rx_data_out),
        .rx_be_out    (rx_be_out),
        .rx_valid_out (rx_valid_out),
        .rx_ready_in  (rx_ready_in),
        .tx_level_out (tx_level_out),
        .rx_level_out (rx_level_out)
    );

    assign usb_data_io = !usb_oe_n_out ? dev_data : {DATA_W{1'bz}};
    assign usb_be_io   = !usb_oe_n_out ? dev_be   : {BE_W{1'bz}};

    always #5 clk_in = ~clk_in;

    // The device acts on the falling edge; everything it samples here is
    // stable up to the next rising edge, so each observed strobe pair is
    // exactly what the DUT will see at that edge.
    always begin
        @(negedge clk_in);
        if (dev_take) dev_idx++;
        usb_rxf_n_in = !(dev_idx < dev_count);
        dev_data     = 32'hA000_0000 | 32'(dev_idx);
        dev_be       = 4'(dev_idx);
        dev_take     = !usb_rd_n_out && !usb_rxf_n_in;
        if (dev_take) burst_takes++;
        usb_txe_n_in = !(tx_acc < tx_limit);
        if (!usb_wr_n_out) begin
            wr_low_cycles++;
            if (!usb_txe_n_in) begin
                tx_words.push_back(usb_data_io);
                tx_bes.push_back(usb_be_io);
                tx_acc++;
            end else begin
                held_word = usb_data_io;
            end
        end
        if (!usb_oe_n_out) oe_low_cycles++;
        if (!usb_oe_n_out && usb_rd_n_out) turn_cycles++;
        if (!usb_oe_n_out && prev_oe) grants.push_back(G_R);
        if (!usb_wr_n_out && prev_wr) grants.push_back(G_T);
        if (usb_rd_n_out && !prev_rd) begin
            burst_log.push_back(burst_takes);
            burst_takes = 0;
        end
        if (rx_valid_out && rx_ready_in) begin
            rx_words.push_back(rx_data_out);
            rx_bes.push_back(rx_be_out);
        end
        prev_oe = usb_oe_n_out;
        prev_wr = usb_wr_n_out;
        prev_rd = usb_rd_n_out;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Pushes one word into the TX buffer from the fabric side.
    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] be);
        tx_data_in  = data;
        tx_be_in    = be;
        tx_valid_in = 1'b1;
        tick(1);
        tx_valid_in = 1'b0;
    endtask

    task automatic clearLog();
        tx_words.delete();
        tx_bes.delete();
        rx_words.delete();
        rx_bes.delete();
        grants.delete();
        burst_log.delete();
        burst_takes   = 0;
        wr_low_cycles = 0;
        oe_low_cycles = 0;
        turn_cycles   = 0;
        tx_acc        = 0;
    endtask

    initial begin
        $display("[TB] start");
        tick(2);

        // Reset state
        checkOutput("rst_wr_n", 32'(usb_wr_n_out), 1);
        checkOutput("rst_rd_n", 32'(usb_rd_n_out), 1);
        checkOutput("rst_oe_n", 32'(usb_oe_n_out), 1);
        checkOutput("rst_tx_level", 32'(tx_level_out), 0);
        checkOutput("rst_rx_level", 32'(rx_level_out), 0);
        checkOutput("rst_rx_valid", 32'(rx_valid_out), 0);
        checkOutput("rst_tx_ready", 32'(tx_ready_out), 1);
        checkOutput("rst_bus_drive", 32'(dut.bus_drive), 0);
        rst_n_in = 1'b1;
        tick(3);

        // TX-only burst of three words while the device also has RX data
        dev_idx   = 0;
        dev_count = 5;
        applyStimulus(32'h1111_1111, 4'h1);
        applyStimulus(32'h2222_2222, 4'h3);
        applyStimulus(32'h3333_3333, 4'hF);
        checkOutput("tx3_preload_level", 32'(tx_level_out), 3);
        clearLog();
        mode_in = 2'b01;
        tick(20);
        checkOutput("tx3_wr_low_cycles", 32'(wr_low_cycles), 3);
        checkOutput("tx3_oe_low_cycles", 32'(oe_low_cycles), 0);
        checkOutput("tx3_grants", 32'(grants.size()), 1);
        checkOutput("tx3_word0", tx_words[0], 32'h1111_1111);
        checkOutput("tx3_word1", tx_words[1], 32'h2222_2222);
        checkOutput("tx3_word2", tx_words[2], 32'h3333_3333);
        checkOutput("tx3_be1", 32'(tx_bes[1]), 32'h3);
        checkOutput("tx3_level", 32'(tx_level_out), 0);
        checkOutput("tx3_wr_n_after", 32'(usb_wr_n_out), 1);
        mode_in = 2'b00;
        tick(2);

        // RX of 20 words split into bursts of 8, 8, 4
        clearLog();
        dev_idx     = 0;
        dev_count   = 20;
        rx_ready_in = 1'b1;
        mode_in     = 2'b10;
        tick(70);
        checkOutput("rx20_bursts", 32'(burst_log.size()), 3);
        checkOutput("rx20_burst0", 32'(burst_log[0]), 8);
        checkOutput("rx20_burst1", 32'(burst_log[1]), 8);
        checkOutput("rx20_burst2", 32'(burst_log[2]), 4);
        checkOutput("rx20_turn_cycles", 32'(turn_cycles), 3);
        checkOutput("rx20_grants", 32'(grants.size()), 3);
        checkOutput("rx20_count", 32'(rx_words.size()), 20);
        for (int i = 0; i < 20; i++)
            checkOutput($sformatf("rx20_word%0d", i), rx_words[i], 32'hA000_0000 | 32'(i));
        checkOutput("rx20_be13", 32'(rx_bes[13]), 32'hD);
        checkOutput("rx20_wr_low", 32'(wr_low_cycles), 0);
        mode_in = 2'b00;
        tick(2);

        // RX back-pressure: the buffer stops one short of full
        clearLog();
        rx_ready_in = 1'b0;
        dev_idx     = 0;
        dev_count   = 18;
        mode_in     = 2'b10;
        tick(40);
        checkOutput("bp_rx_level", 32'(rx_level_out), 15);
        checkOutput("bp_taken", 32'(dev_idx), 15);
        checkOutput("bp_burst1", 32'(burst_log[1]), 7);
        checkOutput("bp_rd_n", 32'(usb_rd_n_out), 1);
        checkOutput("bp_rx_valid", 32'(rx_valid_out), 1);
        checkOutput("bp_head", rx_data_out, 32'hA000_0000);
        tick(3);
        checkOutput("bp_head_stable", rx_data_out, 32'hA000_0000);
        rx_ready_in = 1'b1;
        tick(40);
        checkOutput("bp_drain_count", 32'(rx_words.size()), 18);
        checkOutput("bp_drain_word8", rx_words[8], 32'hA000_0008);
        checkOutput("bp_drain_word17", rx_words[17], 32'hA000_0011);
        checkOutput("bp_drain_level", 32'(rx_level_out), 0);
        mode_in = 2'b00;
        tick(2);

        // TX stall after two of five words; third is held and resent
        dev_count = 0;
        dev_idx   = 0;
        for (int i = 1; i <= 5; i++) applyStimulus(32'h5000_0000 | 32'(i), 4'hF);
        clearLog();
        tx_limit = 2;
        mode_in  = 2'b01;
        tick(15);
        checkOutput("stall_popped", 32'(tx_acc), 2);
        checkOutput("stall_held", held_word, 32'h5000_0003);
        checkOutput("stall_level", 32'(tx_level_out), 3);
        checkOutput("stall_wr_n", 32'(usb_wr_n_out), 1);
        tx_limit = 5;
        tick(15);
        checkOutput("stall_total", 32'(tx_acc), 5);
        checkOutput("stall_word2", tx_words[2], 32'h5000_0003);
        checkOutput("stall_word4", tx_words[4], 32'h5000_0005);
        checkOutput("stall_end_level", 32'(tx_level_out), 0);
        mode_in  = 2'b00;
        tx_limit = 1000;
        tick(2);

        // Fresh reset, then both directions pending: grants alternate from RX
        rst_n_in = 1'b0;
        tick(2);
        rst_n_in = 1'b1;
        for (int i = 0; i < 12; i++) applyStimulus(32'h6000_0000 | 32'(i), 4'hF);
        clearLog();
        dev_idx     = 0;
        dev_count   = 30;
        rx_ready_in = 1'b1;
        mode_in     = 2'b11;
        tick(150);
        checkOutput("rr_grant0", 32'(grants[0]), 32'(G_R));
        checkOutput("rr_grant1", 32'(grants[1]), 32'(G_T));
        checkOutput("rr_grant2", 32'(grants[2]), 32'(G_R));
        checkOutput("rr_grant3", 32'(grants[3]), 32'(G_T));
        checkOutput("rr_tx_count", 32'(tx_words.size()), 12);
        checkOutput("rr_tx_word11", tx_words[11], 32'h6000_000B);
        checkOutput("rr_rx_count", 32'(rx_words.size()), 30);
        checkOutput("rr_rx_word29", rx_words[29], 32'hA000_001D);
        mode_in   = 2'b00;
        dev_count = 0;
        dev_idx   = 0;
        tick(2);

        // Asynchronous reset in the middle of a TX burst
        for (int i = 0; i < 10; i++) applyStimulus(32'h7000_0000 | 32'(i), 4'hF);
        clearLog();
        mode_in = 2'b01;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (!usb_wr_n_out) found = 1'b1;
        end
        checkOutput("mid_tx_started", 32'(found), 1);
        tick(2);
        checkOutput("mid_tx_bus_driven", 32'(dut.bus_drive), 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("mid_rst_wr_n", 32'(usb_wr_n_out), 1);
        checkOutput("mid_rst_rd_n", 32'(usb_rd_n_out), 1);
        checkOutput("mid_rst_oe_n", 32'(usb_oe_n_out), 1);
        checkOutput("mid_rst_bus_drive", 32'(dut.bus_drive), 0);
        checkOutput("mid_rst_tx_level", 32'(tx_level_out), 0);
        checkOutput("mid_rst_rx_level", 32'(rx_level_out), 0);
        tick(2);
        rst_n_in = 1'b1;
        mode_in  = 2'b00;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/usb_fifo_bridge.md
USB_FIFO_BRIDGE -- requirements
Module: usb_fifo_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning USB bus width (16 or 32 only).
REQ-002 SHALL have parameter BE_W, default DATA_W/8, meaning byte-enable width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning words per direction buffer (power of 2, >=4).
REQ-004 SHALL have parameter BURST_MAX, default 8, meaning max words per bus grant before re-arbitration.
REQ-005 SHALL have ports: clk_in  in  1  single clock for USB bus and fabric side.
REQ-006 rst_n_in  in  1  reset, asynchronous, active-low.
REQ-007 mode_in  in  2  00 off, 01 TX only, 10 RX only, 11 both.
REQ-008 usb_txe_n_in  in  1  low = device can accept data; usb_rxf_n_in  in  1  low = device has data.
REQ-009 usb_wr_n_out, usb_rd_n_out, usb_oe_n_out  out  1 each  active-low bus strobes.
REQ-010 usb_data_io  inout  DATA_W  bus data; usb_be_io  inout  BE_W  bus byte enables.
REQ-011 tx_data_in  in  DATA_W; tx_be_in  in  BE_W; tx_valid_in  in  1; tx_ready_out  out  1  fabric-to-USB stream.
REQ-012 rx_data_out  out  DATA_W; rx_be_out  out  BE_W; rx_valid_out  out  1; rx_ready_in  in  1  USB-to-fabric stream.
REQ-013 tx_level_out, rx_level_out  out  $clog2(DEPTH)+1  buffer occupancy.

Function
REQ-014 Fabric transfer SHALL occur on a cycle with valid and ready both high; tx_ready_out = TX buffer not full; rx_valid_out = RX buffer not empty; rx data/be SHALL be first-word-fall-through and stable while valid and not ready.
REQ-015 FSM states SHALL be IDLE, RX_TURN, RX_DATA, TX_DATA, GAP.
REQ-016 IDLE: rx_req = mode_in[1] & !usb_rxf_n_in & RX free >= 2; tx_req = mode_in[0] & !usb_txe_n_in & TX level >= 1.
REQ-017 IDLE SHALL go to RX_TURN on rx_req only, TX_DATA on tx_req only; both set: serve direction not served last (round-robin, RX first after reset).
REQ-018 RX_TURN SHALL last exactly 1 cycle with usb_oe_n_out low, usb_rd_n_out high, then RX_DATA.
REQ-019 RX_DATA: usb_oe_n_out and usb_rd_n_out low; a word+be SHALL be pushed into RX buffer on each clock edge with rd_n low and usb_rxf_n_in low.
REQ-020 RX_DATA SHALL exit to GAP (rd_n high next cycle) when usb_rxf_n_in high, burst count reaches BURST_MAX, or a push leaves free < 2; no word SHALL be pushed into a full buffer.
REQ-021 TX_DATA: bus driven with TX head word/be, usb_wr_n_out low; head SHALL be popped on each edge with wr_n low and usb_txe_n_in low; unpopped head SHALL be held.
REQ-022 TX_DATA SHALL exit to GAP when usb_txe_n_in high, burst count reaches BURST_MAX, or a pop empties the TX buffer.
REQ-023 GAP SHALL last exactly 1 cycle with all strobes high and bus released, then IDLE.
REQ-024 usb_data_io/usb_be_io SHALL be driven only in TX_DATA, high-Z in every other state; all strobes SHALL be registered outputs.
REQ-025 Burst counter SHALL clear on entering RX_DATA/TX_DATA, increment per bus word, width $clog2(BURST_MAX)+1.
REQ-026 mode_in change SHALL take effect only in IDLE; an active burst completes per REQ-020/022.
REQ-027 Simultaneous fabric push and bus pop (or bus push and fabric pop) on same buffer SHALL keep level unchanged, including at full/empty.
REQ-028 Buffer pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH.

Reset
REQ-029 rst_n_in low SHALL asynchronously force state IDLE, strobes high, bus high-Z, both buffers empty, levels 0, rx_valid_out 0, round-robin to RX.
REQ-030 Reset mid-burst SHALL discard buffered data; release SHALL be synchronised so first state change occurs no earlier than second clock after deassertion.

Structure
REQ-031 State enum, mode encodings and DATA_W legality check SHALL live in shared package usb_bridge_pkg.
REQ-032 Both buffers SHALL be instances of one sub-module sync_fifo (FWFT, width DATA_W+BE_W, depth DEPTH, level output).

Verification
REQ-033 TX 3 words (0x11111111..33), txe_n low -> RX_TURN never entered, wr_n low 3 cycles, bus shows 0x11111111,0x22222222,0x33333333, then GAP, tx_level 0.
REQ-034 rxf_n low 20 words, rx_ready_in 1, BURST_MAX 8 -> oe_n low 1 cycle before rd_n, bursts of 8,8,4 separated by GAP+IDLE+RX_TURN, data in order.
REQ-035 rx_ready_in 0, rxf_n low -> pushes stop at DEPTH-1 or DEPTH, rd_n high, no overflow, rx_level_out <= DEPTH.
REQ-036 txe_n high after 2nd of 5 words -> exactly 2 popped, 3rd held on bus until GAP, resumes with 3rd word next grant.
REQ-037 mode 11, both pending continuously -> grants alternate RX,TX,RX; mode 01 -> RX never granted.
REQ-038 rst_n_in low mid-TX burst -> strobes high and bus high-Z same cycle, levels 0.
